// File: rtl/l2_port_arbiter.sv
// l2_port_arbiter: round-robin sharing of the single L2 request port between
// the L1 I-cache (port 0) and the L1 D-cache (port 1).
module l2_port_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int L1_BLOCK_SIZE = 16,
  parameter int TIMEOUT = 255,
  parameter int CNT_WIDTH = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [L1_BLOCK_SIZE-1:0][DATA_WIDTH-1:0] req0_data_in,
  input  logic [L1_BLOCK_SIZE-1:0][DATA_WIDTH-1:0] req1_data_in,
  input  logic req0_read,
  input  logic req1_read,
  input  logic req0_write,
  input  logic req1_write,
  output logic req0_ready,
  output logic req1_ready,
  output logic [L1_BLOCK_SIZE-1:0][DATA_WIDTH-1:0] req0_data_out,
  output logic [L1_BLOCK_SIZE-1:0][DATA_WIDTH-1:0] req1_data_out,
  output logic req0_hit,
  output logic req1_hit,
  output logic [ADDR_WIDTH-1:0] l2_cache_addr,
  output logic [L1_BLOCK_SIZE-1:0][DATA_WIDTH-1:0] l2_cache_data_in,
  output logic l2_cache_read,
  output logic l2_cache_write,
  input  logic l2_cache_ready,
  input  logic [L1_BLOCK_SIZE-1:0][DATA_WIDTH-1:0] l2_cache_data_out,
  input  logic l2_hit,
  output logic grant,
  output logic busy,
  output logic [CNT_WIDTH-1:0] hit_cnt0,
  output logic [CNT_WIDTH-1:0] hit_cnt1,
  output logic [CNT_WIDTH-1:0] req_cnt0,
  output logic [CNT_WIDTH-1:0] req_cnt1,
  output logic err_timeout
);
  localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, RELEASE = 2'd2;
  logic [1:0] state;
  logic last_grant;
  logic [15:0] tcnt;
  logic r0, r1, pick;
  assign r0 = req0_read | req0_write;
  assign r1 = req1_read | req1_write;
  // on a tie the port that was not served last wins
  assign pick = (r0 & r1) ? ~last_grant : r1;
  assign busy = state != IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      grant <= 1'b0;
      last_grant <= 1'b1;
      tcnt <= '0;
      err_timeout <= 1'b0;
      l2_cache_addr <= '0;
      l2_cache_data_in <= '0;
      l2_cache_read <= 1'b0;
      l2_cache_write <= 1'b0;
      req0_ready <= 1'b0;
      req1_ready <= 1'b0;
      req0_hit <= 1'b0;
      req1_hit <= 1'b0;
      req0_data_out <= '0;
      req1_data_out <= '0;
      hit_cnt0 <= '0;
      hit_cnt1 <= '0;
      req_cnt0 <= '0;
      req_cnt1 <= '0;
    end else begin
      req0_ready <= 1'b0;
      req1_ready <= 1'b0;
      case (state)
        IDLE: if (r0 | r1) begin
          grant <= pick;
          l2_cache_addr <= pick ? req1_addr : req0_addr;
          l2_cache_data_in <= pick ? req1_data_in : req0_data_in;
          l2_cache_read <= pick ? req1_read : req0_read;
          l2_cache_write <= pick ? req1_write & ~req1_read : req0_write & ~req0_read;
          req_cnt0 <= req_cnt0 + CNT_WIDTH'(!pick && req_cnt0 != '1);
          req_cnt1 <= req_cnt1 + CNT_WIDTH'(pick && req_cnt1 != '1);
          tcnt <= '0;
          state <= ISSUE;
        end
        ISSUE: if (l2_cache_ready) begin
          l2_cache_read <= 1'b0;
          l2_cache_write <= 1'b0;
          l2_cache_addr <= '0;
          req0_ready <= !grant;
          req1_ready <= grant;
          req0_data_out <= grant ? req0_data_out : l2_cache_data_out;
          req1_data_out <= grant ? l2_cache_data_out : req1_data_out;
          req0_hit <= grant ? req0_hit : l2_hit;
          req1_hit <= grant ? l2_hit : req1_hit;
          hit_cnt0 <= hit_cnt0 + CNT_WIDTH'(!grant && l2_hit && hit_cnt0 != '1);
          hit_cnt1 <= hit_cnt1 + CNT_WIDTH'(grant && l2_hit && hit_cnt1 != '1);
          last_grant <= grant;
          state <= RELEASE;
        end else begin
          // no abort on timeout: the flag is sticky and only rst recovers
          tcnt <= tcnt == 16'(TIMEOUT) ? tcnt : tcnt + 16'd1;
          err_timeout <= err_timeout | (tcnt >= 16'(TIMEOUT - 1));
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
